// File: rtl/jtframe_dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter.
//   state_t : arbiter FSM encoding (IDLE, ISSUE, READ, CLEAR), 2 bits wide.
//   REQ_A / REQ_B : requester-select values used for the grant record and
//                   the round-robin pointer.
package jtframe_dpram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/jtframe_rr2.sv
// Two-way round-robin grant.
//   clk, rst_n : clock and synchronous active-low reset
//   pend_a/b   : requester has an outstanding access
//   advance    : a grant is being taken this cycle
//   grant      : one-hot grant, bit 0 = A, bit 1 = B (combinational)
// The pointer only moves when both requesters compete, so a lone requester
// never steals the turn of the other one.
module jtframe_rr2
    import jtframe_dpram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pend_a,
    input  logic       pend_b,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Grant and pointer update live in separate blocks: advance is derived
    // from grant in the parent, so mixing them would form a block-level loop.
    always_comb begin
        grant = 2'b00;
        if (pend_a && pend_b) begin
            grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
        end else if (pend_a) begin
            grant = 2'b01;
        end else if (pend_b) begin
            grant = 2'b10;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && pend_a && pend_b) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/jtframe_dpram_arb.sv
// Shares port 0 of a jtframe_dual_ram_cen (cen high) between requesters A and
// B; port 1 stays free for a fixed-latency consumer such as a video scan.
// Optional clear engine, enabled by the macro JTFRAME_DPRAM_ARB_CLEAR_EN,
// fills the RAM with CLRVAL after reset and on a rising clr.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   x_cs/x_addr/x_wr/x_din/x_dout/x_ok (x = a, b)   requester interfaces
//   ram_addr/ram_data/ram_we   registered drive of RAM port 0
//   ram_q               RAM port 0 read data (registered inside the RAM)
//   clr                 rising edge restarts the clear engine
//   busy                high while clearing
//   dbg_state           current FSM state
//
// Handshake: a requester raises x_cs (level) with x_addr/x_wr/x_din stable at
// grant; those are sampled once at grant. x_ok rises when the access is done
// and stays high while x_cs stays high; it drops the cycle after x_cs falls.
// A new access needs x_cs low for at least one cycle. An access is pending
// while x_cs & ~x_ok. If x_cs drops before completion the RAM cycle still runs
// but x_ok is not raised.
module jtframe_dpram_arb
    import jtframe_dpram_arb_pkg::*;
#(
    parameter int              dw     = 8,
    parameter int              aw     = 10,
    parameter logic [dw-1:0]   CLRVAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_cs,
    input  logic [aw-1:0] a_addr,
    input  logic          a_wr,
    input  logic [dw-1:0] a_din,
    output logic [dw-1:0] a_dout,
    output logic          a_ok,
    input  logic          b_cs,
    input  logic [aw-1:0] b_addr,
    input  logic          b_wr,
    input  logic [dw-1:0] b_din,
    output logic [dw-1:0] b_dout,
    output logic          b_ok,
    output logic [aw-1:0] ram_addr,
    output logic [dw-1:0] ram_data,
    output logic          ram_we,
    input  logic [dw-1:0] ram_q,
    input  logic          clr,
    output logic          busy,
    output state_t        dbg_state
);

`ifdef JTFRAME_DPRAM_ARB_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    state_t        state_q,    state_d;
    logic          sel_q,      sel_d;
    logic [aw-1:0] ram_addr_q, ram_addr_d;
    logic [dw-1:0] ram_data_q, ram_data_d;
    logic          ram_we_q,   ram_we_d;
    logic [dw-1:0] a_dout_q,   a_dout_d;
    logic [dw-1:0] b_dout_q,   b_dout_d;
    logic          a_ok_q,     a_ok_d;
    logic          b_ok_q,     b_ok_d;
    logic          busy_q,     busy_d;
    // One extra bit so the step past the last address is visible as a carry.
    logic [aw:0]   cnt_q,      cnt_d;
    logic          clr_prev_q, clr_prev_d;
    logic          clr_pend_q, clr_pend_d;

    logic          pend_a;
    logic          pend_b;
    logic [1:0]    grant;
    logic          clr_rise;
    logic          clear_go;
    logic          advance;

    assign pend_a   = a_cs & ~a_ok_q;
    assign pend_b   = b_cs & ~b_ok_q;
    assign clr_rise = CLEAR_EN & clr & ~clr_prev_q;
    // clr_pend_q also carries the post-reset clear request.
    assign clear_go = clr_pend_q | clr_rise;
    assign advance  = (state_q == IDLE) && !clear_go && (grant != 2'b00);

    jtframe_rr2 u_rr2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .pend_a  (pend_a),
        .pend_b  (pend_b),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = ram_we_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        a_ok_d     = a_ok_q & a_cs;
        b_ok_d     = b_ok_q & b_cs;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        clr_prev_d = clr;
        clr_pend_d = clr_pend_q | clr_rise;

        case (state_q)
            IDLE: begin
                ram_we_d = 1'b0;
                if (clear_go) begin
                    state_d    = CLEAR;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    ram_data_d = CLRVAL;
                    ram_we_d   = 1'b1;
                    clr_pend_d = 1'b0;
                end else if (advance) begin
                    state_d = ISSUE;
                    if (grant[1]) begin
                        sel_d      = REQ_B;
                        ram_addr_d = b_addr;
                        ram_data_d = b_din;
                        ram_we_d   = b_wr;
                    end else begin
                        sel_d      = REQ_A;
                        ram_addr_d = a_addr;
                        ram_data_d = a_din;
                        ram_we_d   = a_wr;
                    end
                end
            end
            ISSUE: begin
                // RAM takes the address now; the write pulse ends here.
                ram_we_d = 1'b0;
                state_d  = READ;
            end
            READ: begin
                // Registered RAM output is valid; on writes it is the old data.
                if (sel_q == REQ_A) begin
                    a_dout_d = ram_q;
                    a_ok_d   = a_cs;
                end else begin
                    b_dout_d = ram_q;
                    b_ok_d   = b_cs;
                end
                state_d = IDLE;
            end
            CLEAR: begin
                ram_we_d   = 1'b1;
                ram_data_d = CLRVAL;
                if (clr_rise) begin
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    clr_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d[aw]) begin
                        ram_we_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        ram_addr_d = cnt_d[aw-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= REQ_A;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            a_ok_q     <= 1'b0;
            b_ok_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            clr_prev_q <= 1'b0;
            clr_pend_q <= CLEAR_EN;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
            a_ok_q     <= a_ok_d;
            b_ok_q     <= b_ok_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            clr_prev_q <= clr_prev_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;
    assign a_dout    = a_dout_q;
    assign b_dout    = b_dout_q;
    assign a_ok      = a_ok_q;
    assign b_ok      = b_ok_q;
    assign busy      = CLEAR_EN ? busy_q : 1'b0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jtframe_dpram_arb.sv
// Bench for jtframe_dpram_arb with aw=4, dw=8, CLRVAL=8'h5A, driving a
// behavioural model of RAM port 0 (registered read, read-before-write).
module tb_jtframe_dpram_arb;
    import jtframe_dpram_arb_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       a_cs   = 1'b0;
    logic [3:0] a_addr = '0;
    logic       a_wr   = 1'b0;
    logic [7:0] a_din  = '0;
    logic [7:0] a_dout;
    logic       a_ok;
    logic       b_cs   = 1'b0;
    logic [3:0] b_addr = '0;
    logic       b_wr   = 1'b0;
    logic [7:0] b_din  = '0;
    logic [7:0] b_dout;
    logic       b_ok;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_q  = '0;
    logic       clr    = 1'b0;
    logic       busy;
    state_t     dbg_state;

    always #5 clk = ~clk;

    jtframe_dpram_arb #(.dw(8), .aw(4), .CLRVAL(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_cs(a_cs), .a_addr(a_addr), .a_wr(a_wr), .a_din(a_din), .a_dout(a_dout), .a_ok(a_ok),
        .b_cs(b_cs), .b_addr(b_addr), .b_wr(b_wr), .b_din(b_din), .b_dout(b_dout), .b_ok(b_ok),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .clr(clr), .busy(busy), .dbg_state(dbg_state)
    );

    // RAM port 0 model
    logic [7:0] mem [16] = '{default: 8'h00};
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_data;
    end

    // activity monitors
    int we_cnt    = 0;
    int issue_cnt = 0;
    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (dbg_state == ISSUE) issue_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] ref_mem [16];
    logic       ptr_b = 1'b0;
    int         total = 0;
    int         bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic issue(input logic is_b, input logic [3:0] addr, input logic wr, input logic [7:0] din);
        if (!is_b) begin
            a_cs = 1'b1; a_addr = addr; a_wr = wr; a_din = din;
            exp_a_q.push_back(ref_mem[addr]);
        end else begin
            b_cs = 1'b1; b_addr = addr; b_wr = wr; b_din = din;
            exp_b_q.push_back(ref_mem[addr]);
        end
        if (wr) ref_mem[addr] = din;
    endtask

    // Both requesters at once; the model serves them in pointer order.
    task automatic issue_pair(input logic [3:0] aa, input logic aw_, input logic [7:0] ad,
                              input logic [3:0] ba, input logic bw_, input logic [7:0] bd);
        if (!ptr_b) begin
            issue(1'b0, aa, aw_, ad); issue(1'b1, ba, bw_, bd);
        end else begin
            issue(1'b1, ba, bw_, bd); issue(1'b0, aa, aw_, ad);
        end
        ptr_b = ~ptr_b;
    endtask

    task automatic drop_cs();
        a_cs = 1'b0; b_cs = 1'b0;
        @(posedge clk); #1;
    endtask

    // Samples ncyc cycles (index 0 = current cycle) and records first ok cycles.
    task automatic watch(input int ncyc, output int a_first, output int b_first,
                         output logic [7:0] a_val, output logic [7:0] b_val,
                         output int a_hi, output int busy_last);
        a_first = -1; b_first = -1; a_val = '0; b_val = '0; a_hi = 0; busy_last = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (a_ok) begin
                a_hi++;
                if (a_first < 0) begin a_first = i; a_val = a_dout; end
            end
            if (b_ok && b_first < 0) begin b_first = i; b_val = b_dout; end
            if (busy) busy_last = i;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rv;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rv = {ram_addr, ram_data, ram_we, a_dout, b_dout, a_ok, b_ok, busy};
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL reset_vals: got %h expected 0", rv); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifndef JTFRAME_DPRAM_ARB_CLEAR_EN
        @(negedge clk);
        total++; if ({busy, dbg_state} !== {1'b0, IDLE}) begin bad++; $display("FAIL post_reset: got busy=%b st=%0d expected busy=0 st=0", busy, dbg_state); end
        @(posedge clk); #1;
`endif
    endtask

`ifdef JTFRAME_DPRAM_ARB_CLEAR_EN
    task automatic test_clear();
        logic [3:0] ia;
        for (int i = 0; i < 16; i++) begin
            ia = 4'(i);
            @(negedge clk);
            total++;
            if ({busy, ram_we, ram_addr, ram_data} !== {1'b1, 1'b1, ia, 8'h5A}) begin
                bad++; $display("FAIL clear_step%0d: got busy=%b we=%b addr=%0d data=%h expected 1 1 %0d 5a", i, busy, ram_we, ram_addr, ram_data, ia);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if ({busy, ram_we, dbg_state} !== {1'b0, 1'b0, IDLE}) begin bad++; $display("FAIL clear_end: got busy=%b we=%b st=%0d expected 0 0 0", busy, ram_we, dbg_state); end
        for (int i = 0; i < 16; i++) begin
            total++; if (mem[i] !== 8'h5A) begin bad++; $display("FAIL clear_mem%0d: got %h expected 5a", i, mem[i]); end
            ref_mem[i] = 8'h5A;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_req_during_clear();
        int af, bf, ah, bl; logic [7:0] av, bv;
        clr = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h5A;
        watch(5, af, bf, av, bv, ah, bl);
        clr = 1'b0;
        issue(1'b1, 4'd7, 1'b0, 8'h00);
        watch(30, af, bf, av, bv, ah, bl);
        total++; if (bl !== 11) begin bad++; $display("FAIL clr_busy_last: got %0d expected 11", bl); end
        total++; if (bf !== 15) begin bad++; $display("FAIL clr_b_ok: got %0d expected 15", bf); end
        total++; if (af !== -1) begin bad++; $display("FAIL clr_a_ok: got %0d expected -1", af); end
        total++; if (bv !== exp_b_q.pop_front()) begin bad++; $display("FAIL clr_b_dout: got %h expected 5a", bv); end
        drop_cs();
    endtask
`endif

    task automatic test_write_read();
        int af, bf, ah, bl, we0; logic [7:0] av, bv, e;
        we0 = we_cnt;
        issue(1'b0, 4'd7, 1'b1, 8'h3C);
        watch(8, af, bf, av, bv, ah, bl);
        e = exp_a_q.pop_front();
        total++; if (af !== 3) begin bad++; $display("FAIL wr_latency: got %0d expected 3", af); end
        total++; if (av !== e) begin bad++; $display("FAIL wr_old_dout: got %h expected %h", av, e); end
        total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL wr_we_pulse: got %0d expected 1", we_cnt - we0); end
        total++; if (mem[7] !== 8'h3C) begin bad++; $display("FAIL wr_mem: got %h expected 3c", mem[7]); end
        drop_cs();
        we0 = we_cnt;
        issue(1'b0, 4'd7, 1'b0, 8'h00);
        watch(8, af, bf, av, bv, ah, bl);
        e = exp_a_q.pop_front();
        total++; if (af !== 3) begin bad++; $display("FAIL rd_latency: got %0d expected 3", af); end
        total++; if (av !== e) begin bad++; $display("FAIL rd_dout: got %h expected %h", av, e); end
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL rd_no_we: got %0d expected 0", we_cnt - we0); end
        drop_cs();
    endtask

    task automatic test_simultaneous();
        int af, bf, ah, bl; logic [7:0] av, bv, ea, eb;
        issue_pair(4'd1, 1'b1, 8'h11, 4'd1, 1'b0, 8'h00);
        watch(12, af, bf, av, bv, ah, bl);
        ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
        total++; if (af !== 3) begin bad++; $display("FAIL sim1_a_ok: got %0d expected 3", af); end
        total++; if (bf !== 6) begin bad++; $display("FAIL sim1_b_ok: got %0d expected 6", bf); end
        total++; if (bv !== eb) begin bad++; $display("FAIL sim1_b_dout: got %h expected %h", bv, eb); end
        total++; if (av !== ea) begin bad++; $display("FAIL sim1_a_dout: got %h expected %h", av, ea); end
        drop_cs();
        issue_pair(4'd2, 1'b0, 8'h00, 4'd2, 1'b1, 8'h22);
        watch(12, af, bf, av, bv, ah, bl);
        ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
        total++; if (bf !== 3) begin bad++; $display("FAIL sim2_b_ok: got %0d expected 3", bf); end
        total++; if (af !== 6) begin bad++; $display("FAIL sim2_a_ok: got %0d expected 6", af); end
        total++; if (av !== ea) begin bad++; $display("FAIL sim2_a_dout: got %h expected %h", av, ea); end
        drop_cs();
    endtask

    task automatic test_held_cs();
        int af, bf, ah, bl, is0; logic [7:0] av, bv, e;
        is0 = issue_cnt;
        issue(1'b0, 4'd1, 1'b0, 8'h00);
        watch(10, af, bf, av, bv, ah, bl);
        e = exp_a_q.pop_front();
        total++; if (af !== 3) begin bad++; $display("FAIL held_latency: got %0d expected 3", af); end
        total++; if (ah !== 7) begin bad++; $display("FAIL held_ok_cycles: got %0d expected 7", ah); end
        total++; if (issue_cnt - is0 !== 1) begin bad++; $display("FAIL held_accesses: got %0d expected 1", issue_cnt - is0); end
        total++; if (av !== e) begin bad++; $display("FAIL held_dout: got %h expected %h", av, e); end
        a_cs = 1'b0;
        @(negedge clk);
        total++; if (a_ok !== 1'b1) begin bad++; $display("FAIL held_ok_drop_same: got %b expected 1", a_ok); end
        @(negedge clk);
        total++; if (a_ok !== 1'b0) begin bad++; $display("FAIL held_ok_drop_next: got %b expected 0", a_ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int af, bf, ah, bl, kind, ea_first, eb_first; logic [7:0] av, bv, e;
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                ea_first = 3; eb_first = -1;
                issue(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else if (kind == 1) begin
                ea_first = -1; eb_first = 3;
                issue(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else begin
                ea_first = ptr_b ? 6 : 3; eb_first = ptr_b ? 3 : 6;
                issue_pair(4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                           4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
            watch(10, af, bf, av, bv, ah, bl);
            total++; if (af !== ea_first) begin bad++; $display("FAIL b2b%0d_a_ok: got %0d expected %0d", it, af, ea_first); end
            total++; if (bf !== eb_first) begin bad++; $display("FAIL b2b%0d_b_ok: got %0d expected %0d", it, bf, eb_first); end
            if (ea_first >= 0) begin
                e = exp_a_q.pop_front();
                total++; if (av !== e) begin bad++; $display("FAIL b2b%0d_a_dout: got %h expected %h", it, av, e); end
            end
            if (eb_first >= 0) begin
                e = exp_b_q.pop_front();
                total++; if (bv !== e) begin bad++; $display("FAIL b2b%0d_b_dout: got %h expected %h", it, bv, e); end
            end
            drop_cs();
        end
    endtask

    task automatic test_reset_mid_access();
        int af, bf, ah, bl; logic [7:0] av, bv; logic [31:0] rv;
        a_cs = 1'b1; a_addr = 4'd2; a_wr = 1'b1; a_din = 8'h99;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({dbg_state, ram_we} !== {ISSUE, 1'b1}) begin bad++; $display("FAIL rstmid_issue: got st=%0d we=%b expected st=1 we=1", dbg_state, ram_we); end
        rst_n = 1'b0;
        @(negedge clk);
        rv = {ram_addr, ram_data, ram_we, a_dout, b_dout, a_ok, b_ok, busy};
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rstmid_vals: got %h expected 0", rv); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state); end
        a_cs = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_b = 1'b0;
        watch(6, af, bf, av, bv, ah, bl);
        total++; if (af !== -1) begin bad++; $display("FAIL rstmid_no_ok: got %0d expected -1", af); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
`ifdef JTFRAME_DPRAM_ARB_CLEAR_EN
        test_clear();
`endif
        test_write_read();
        test_simultaneous();
        test_held_cs();
        test_back_to_back();
`ifdef JTFRAME_DPRAM_ARB_CLEAR_EN
        test_req_during_clear();
`endif
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
